// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: fetches one word per PC over a req/ack memory
// handshake and holds it in an instruction register for the decoder.
module instruction_fetch_stage #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_inst,
    input  logic              flush,
    output logic              pc_advance,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_FULL  = 3'd2;
    localparam logic [2:0] S_DROP  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0] state;
    logic [7:0] wait_cnt;
    logic       timeout;

    assign timeout = (wait_cnt == 8'(MAX_WAIT));

    // Combinational so the PC steps on the same edge that captures the word,
    // and can never coincide with a flush.
    assign pc_advance = (state == S_WAIT) && mem_ack && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            inst_out    <= '0;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_addr <= addr_inst;
                    mem_req  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT, S_DROP: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if ((state == S_WAIT) && !flush) begin
                            inst_out   <= mem_rdata;
                            inst_pc    <= mem_addr;
                            inst_valid <= 1'b1;
                            state      <= S_FULL;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (timeout) begin
                        mem_req     <= 1'b0;
                        fetch_fault <= 1'b1;
                        state       <= S_FAULT;
                    end else begin
                        if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                        // Request stays up; the returning word is discarded later.
                        if (flush) begin
                            state <= S_DROP;
                        end
                    end
                end
                S_FULL: begin
                    if (flush || inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    mem_req     <= 1'b0;
                    inst_valid  <= 1'b0;
                    fetch_fault <= 1'b1;
                end
                default: begin
                    mem_req    <= 1'b0;
                    inst_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized scoreboard bench for instruction_fetch_stage with a PC/memory
// environment model and directed reset, throughput and timeout scenarios.
module tb_instruction_fetch_stage;

    localparam int unsigned MAX_WAIT = 15;

    logic        clk;
    logic        reset_n;
    logic [15:0] addr_inst;
    logic        flush;
    logic        pc_advance;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_fault;

    instruction_fetch_stage #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr_inst  (addr_inst),
        .flush      (flush),
        .pc_advance (pc_advance),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_xfer   = 0;

    logic [31:0] sb_q[$];      // {data, pc} of each instruction due to the decoder
    logic [15:0] exp_pc;       // reference PC: +1 per delivered fetch, redirect on flush
    logic [15:0] fetch_addr;
    logic        req_prev;
    logic        flushed;
    int unsigned age;
    int unsigned ack_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [31:0] p;
        p = {16'd0, a} * 32'h0000_9E37;
        return p[15:0] ^ 16'h1234;
    endfunction

    // One clock of environment: memory responder, random flush/ready, PC model.
    // Entered and left at a falling edge.
    task automatic step(input int unsigned ack_max, input int unsigned flush_pct,
                        input int unsigned ready_pct, input bit no_ack);
        logic        req;
        logic        adv_exp;
        logic [15:0] nxt;
        req = mem_req;
        if (req && !req_prev) begin
            check("fetch_addr", {16'd0, mem_addr}, {16'd0, exp_pc});
            fetch_addr = exp_pc;
            flushed    = 1'b0;
            age        = 0;
            ack_at     = $urandom_range(0, ack_max);
        end else if (req) begin
            check("mem_addr_stable", {16'd0, mem_addr}, {16'd0, fetch_addr});
        end
        mem_ack    = 1'b0;
        flush      = 1'b0;
        inst_ready = ($urandom_range(0, 99) < ready_pct);
        mem_rdata  = 16'($urandom);
        if (req) begin
            if (!no_ack && age == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = memf(fetch_addr);
            end
            age++;
        end
        if ((req || inst_valid) && ($urandom_range(0, 99) < flush_pct)) flush = 1'b1;
        adv_exp = mem_ack && !flush && !flushed;
        #1;
        if (mem_ack || pc_advance) check("pc_advance", {31'd0, pc_advance}, {31'd0, adv_exp});
        if (adv_exp) sb_q.push_back({memf(fetch_addr), fetch_addr});
        if (req && flush) flushed = 1'b1;
        nxt = exp_pc;
        if (flush) nxt = 16'($urandom);
        else if (adv_exp) nxt = exp_pc + 16'd1;
        req_prev = req;
        @(posedge clk);
        #1;
        exp_pc    = nxt;
        addr_inst = exp_pc;
        @(negedge clk);
    endtask

    task automatic hold_reset(input bit ack_noise);
        reset_n = 1'b0;
        flush   = 1'b0;
        repeat (2) begin
            mem_ack   = ack_noise;
            mem_rdata = 16'($urandom);
            @(negedge clk);
        end
        mem_ack  = 1'b0;
        sb_q.delete();
        req_prev = 1'b0;
        reset_n  = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every transfer or flushed instruction.
    always begin
        logic [31:0] e;
        @(negedge clk);
        #2;
        if (reset_n && inst_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_inst_valid: got inst_out %0h pc %0h expected no instruction", inst_out, inst_pc);
            end else if (flush) begin
                void'(sb_q.pop_front());
            end else if (inst_ready) begin
                e = sb_q.pop_front();
                check("inst_out", {16'd0, inst_out}, {16'd0, e[31:16]});
                check("inst_pc", {16'd0, inst_pc}, {16'd0, e[15:0]});
                n_xfer++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned x0;
        int unsigned cnt;
        reset_n    = 1'b0;
        addr_inst  = 16'h0000;
        exp_pc     = 16'h0000;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        inst_ready = 1'b0;
        req_prev   = 1'b0;
        flushed    = 1'b0;
        fetch_addr = 16'h0000;
        age        = 0;
        ack_at     = 0;
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_pc_advance", {31'd0, pc_advance}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_inst_out", {16'd0, inst_out}, 32'd0);
        check("rst_inst_pc", {16'd0, inst_pc}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("req_at_release", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("req_after_idle", {31'd0, mem_req}, 32'd1);
        @(negedge clk);

        // Zero-wait memory and an always-ready decoder: one word per 3 cycles.
        repeat (6) step(0, 0, 100, 1'b0);
        x0 = n_xfer;
        repeat (30) step(0, 0, 100, 1'b0);
        check("throughput", n_xfer - x0, 32'd10);

        repeat (400) step(3, 10, 70, 1'b0);
        repeat (400) step(1, 25, 30, 1'b0);
        repeat (400) step(0, 5, 100, 1'b0);
        repeat (400) step(2, 15, 10, 1'b0);
        repeat (20) step(0, 0, 100, 1'b0);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        check("transfers_seen", {31'd0, n_xfer > 100}, 32'd1);

        // Asynchronous reset while a request is outstanding.
        cnt = 0;
        while (!mem_req && cnt < 10) begin
            step(0, 0, 100, 1'b1);
            cnt++;
        end
        check("req_before_reset", {31'd0, mem_req}, 32'd1);
        step(0, 0, 100, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("async_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        hold_reset(1'b1);
        check("ack_in_reset_ignored", {31'd0, inst_valid}, 32'd0);
        x0 = n_xfer;
        repeat (20) step(1, 0, 100, 1'b0);
        check("refetch_after_reset", {31'd0, n_xfer > x0}, 32'd1);
        repeat (6) step(0, 0, 100, 1'b0);
        check("scoreboard_drained_2", sb_q.size(), 32'd0);

        // Memory never answers: timeout after MAX_WAIT+1 cycles of request.
        hold_reset(1'b0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (fetch_fault) break;
            if (mem_req) cnt++;
            step(0, 0, 100, 1'b1);
        end
        check("fault_set", {31'd0, fetch_fault}, 32'd1);
        check("req_cycles_to_fault", cnt, MAX_WAIT + 1);
        check("fault_mem_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            mem_ack    = 1'b1;
            mem_rdata  = 16'($urandom);
            inst_ready = 1'b1;
            #1;
            check("fault_pc_advance", {31'd0, pc_advance}, 32'd0);
            @(negedge clk);
            check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
            check("fault_no_req", {31'd0, mem_req}, 32'd0);
            check("fault_no_valid", {31'd0, inst_valid}, 32'd0);
        end
        mem_ack = 1'b0;
        reset_n = 1'b0;
        #1;
        check("fault_cleared", {31'd0, fetch_fault}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
